flight_mixer_core: RTL

- Parametrised successor to the fixed four-motor offset/summer/PWM chain in the flight controller top level.
- Captures one receiver sample set (pitch, roll, yaw, throttle) and mixes it into NUM_MOTORS commands using a per-motor sign table, with saturation.
- Gates the outputs through an arming/failsafe state machine and drives one glitch-free PWM output per motor.
- Sits between the receiver_reader instances and the motor pins, replacing the offset generators, motor_offset_summer and pwm_generator instances.

---
 rtl/flight_mixer_core.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/flight_mixer_core.sv
// flight_mixer_core
// Captures one receiver sample set, mixes it into NUM_MOTORS commands using a
// per-motor sign table with saturation, gates the commands through an
// arming/failsafe state machine and drives one glitch-free PWM output per motor.
//
// Ports:
//   clk, rst             system clock, synchronous active-high reset
//   rx_valid             one-cycle strobe qualifying pitch/roll/yaw/throttle
//   pitch, roll, yaw     offset-binary axes, centre 2^(CMD_W-1)
//   throttle             unsigned throttle
//   arm_req              level-sensitive arm switch
//   motor_cmd            registered mixed commands, motor m at [m*CMD_W +: CMD_W]
//   motor_pwm            registered PWM outputs, one per motor
//   state                0 = DISARMED, 1 = ARMED, 2 = FAILSAFE
//   failsafe             high while state == FAILSAFE
module flight_mixer_core #(
  parameter int                      NUM_MOTORS      = 4,
  parameter int                      CMD_W           = 8,
  parameter logic [3*NUM_MOTORS-1:0] MIX_SIGNS       = 12'b101_011_000_110,
  parameter int                      IDLE_CMD        = 20,
  parameter int                      ARM_THR_MAX     = 10,
  parameter int                      FAILSAFE_CYCLES = 1000000,
  parameter int                      PWM_DIV         = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx_valid,
  input  logic [CMD_W-1:0]            pitch,
  input  logic [CMD_W-1:0]            roll,
  input  logic [CMD_W-1:0]            yaw,
  input  logic [CMD_W-1:0]            throttle,
  input  logic                        arm_req,
  output logic [NUM_MOTORS*CMD_W-1:0] motor_cmd,
  output logic [NUM_MOTORS-1:0]       motor_pwm,
  output logic [1:0]                  state,
  output logic                        failsafe
);

  // Three guard bits keep throttle +/- three centred axes free of overflow.
  localparam int SUM_W = CMD_W + 3;
  localparam int WD_W  = $clog2(FAILSAFE_CYCLES + 1);
  localparam int PRE_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

  localparam logic [CMD_W-1:0]        CMD_MAX  = {CMD_W{1'b1}};
  localparam logic signed [SUM_W-1:0] CENTRE_S = SUM_W'(32'd1 << (CMD_W - 1));
  localparam logic signed [SUM_W-1:0] IDLE_S   = SUM_W'(IDLE_CMD);
  localparam logic signed [SUM_W-1:0] MAX_S    = $signed({3'b000, CMD_MAX});

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_FAILSAFE = 2'd2
  } state_t;

  logic [CMD_W-1:0]            pitch_h_r, roll_h_r, yaw_h_r, throttle_h_r;
  logic                        rx_seen_r;
  logic [WD_W-1:0]             wd_cnt_r;
  state_t                      state_r;
  logic                        failsafe_r;
  logic [NUM_MOTORS*CMD_W-1:0] motor_cmd_r;
  logic [NUM_MOTORS*CMD_W-1:0] duty_r;
  logic [CMD_W-1:0]            pwm_cnt_r;
  logic [PRE_W-1:0]            presc_r;
  logic [NUM_MOTORS-1:0]       motor_pwm_r;

  logic                        expired_s;
  logic                        trip_s;
  logic                        pwm_tick_s;
  logic signed [SUM_W-1:0]     thr_s, p_s, r_s, y_s;
  logic [NUM_MOTORS*CMD_W-1:0] mix_s;

  // Mix one motor: signs = {yaw, roll, pitch}, 1 subtracts the term; result
  // is clamped to [IDLE_CMD, 2^CMD_W-1].
  function automatic logic [CMD_W-1:0] mix_one(
    input logic [2:0]              signs,
    input logic signed [SUM_W-1:0] thr,
    input logic signed [SUM_W-1:0] p,
    input logic signed [SUM_W-1:0] r,
    input logic signed [SUM_W-1:0] y
  );
    logic signed [SUM_W-1:0] sum;
    sum = thr;
    sum = signs[0] ? (sum - p) : (sum + p);
    sum = signs[1] ? (sum - r) : (sum + r);
    sum = signs[2] ? (sum - y) : (sum + y);
    if (sum < IDLE_S) begin
      mix_one = CMD_W'(IDLE_CMD);
    end else if (sum > MAX_S) begin
      mix_one = CMD_MAX;
    end else begin
      mix_one = sum[CMD_W-1:0];
    end
  endfunction

  assign expired_s  = (wd_cnt_r == WD_W'(FAILSAFE_CYCLES));
  // A fresh sample arriving while the watchdog sits at its limit rescues the link.
  assign trip_s     = expired_s && !rx_valid;
  assign pwm_tick_s = (presc_r == PRE_W'(PWM_DIV - 1));

  assign thr_s = $signed({3'b000, throttle_h_r});
  assign p_s   = $signed({3'b000, pitch_h_r}) - CENTRE_S;
  assign r_s   = $signed({3'b000, roll_h_r})  - CENTRE_S;
  assign y_s   = $signed({3'b000, yaw_h_r})   - CENTRE_S;

  // Combinational mix of the held sample for every motor.
  always_comb begin
    mix_s = '0;
    for (int m = 0; m < NUM_MOTORS; m++) begin
      mix_s[m*CMD_W +: CMD_W] = mix_one(MIX_SIGNS[3*m +: 3], thr_s, p_s, r_s, y_s);
    end
  end

  // Receiver sample hold registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pitch_h_r    <= '0;
      roll_h_r     <= '0;
      yaw_h_r      <= '0;
      throttle_h_r <= '0;
      rx_seen_r    <= 1'b0;
    end else if (rx_valid) begin
      pitch_h_r    <= pitch;
      roll_h_r     <= roll;
      yaw_h_r      <= yaw;
      throttle_h_r <= throttle;
      rx_seen_r    <= 1'b1;
    end
  end

  // Link-loss watchdog: counts idle cycles, saturates at FAILSAFE_CYCLES.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_r <= '0;
    end else if (rx_valid) begin
      wd_cnt_r <= '0;
    end else if (!expired_s) begin
      wd_cnt_r <= wd_cnt_r + WD_W'(1);
    end
  end

  // Arming / failsafe state machine.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_DISARMED;
      failsafe_r <= 1'b0;
    end else begin
      case (state_r)
        ST_DISARMED: begin
          if (arm_req && rx_seen_r && !expired_s &&
              (throttle_h_r <= CMD_W'(ARM_THR_MAX))) begin
            state_r <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          // Dropping the switch beats a simultaneous link loss.
          if (!arm_req) begin
            state_r <= ST_DISARMED;
          end else if (trip_s) begin
            state_r    <= ST_FAILSAFE;
            failsafe_r <= 1'b1;
          end
        end
        ST_FAILSAFE: begin
          if (!arm_req && !expired_s) begin
            state_r    <= ST_DISARMED;
            failsafe_r <= 1'b0;
          end
        end
        default: begin
          state_r    <= ST_DISARMED;
          failsafe_r <= 1'b0;
        end
      endcase
    end
  end

  // Registered motor commands, forced to zero unless armed.
  always_ff @(posedge clk) begin
    if (rst) begin
      motor_cmd_r <= '0;
    end else if (state_r == ST_ARMED) begin
      motor_cmd_r <= mix_s;
    end else begin
      motor_cmd_r <= '0;
    end
  end

  // PWM prescaler, period counter, per-period duty latch and comparators.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_r     <= '0;
      pwm_cnt_r   <= '0;
      duty_r      <= '0;
      motor_pwm_r <= '0;
    end else begin
      presc_r <= pwm_tick_s ? '0 : (presc_r + PRE_W'(1));
      if (pwm_tick_s) begin
        pwm_cnt_r <= pwm_cnt_r + CMD_W'(1);
        // Duty only changes at the period boundary, keeping pulses glitch-free.
        if (pwm_cnt_r == CMD_MAX) begin
          duty_r <= motor_cmd_r;
        end
      end
      for (int m = 0; m < NUM_MOTORS; m++) begin
        motor_pwm_r[m] <= (pwm_cnt_r < duty_r[m*CMD_W +: CMD_W]);
      end
    end
  end

  assign motor_cmd = motor_cmd_r;
  assign motor_pwm = motor_pwm_r;
  assign state     = state_r;
  assign failsafe  = failsafe_r;

endmodule
